// File: rtl/unary_stream_collector.sv
// Collects a valid-qualified serial unary result stream (LSB first) into a parallel word with a bounded capture window.
// Optional UNARY_POPCOUNT_EN adds a registered ones_count output tracking the number of 1s captured.
module unary_stream_collector #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH  = $clog2(INPUT_WIDTH + 1),
    parameter int unsigned WINDOW       = 2 * INPUT_WIDTH + 1,
    parameter int unsigned WINDOW_WIDTH = $clog2(WINDOW + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   y,
    input  logic                   valid,
    output logic [INPUT_WIDTH-1:0] word_out,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow
`ifdef UNARY_POPCOUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] ones_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [COUNT_WIDTH-1:0]  LAST_BIT   = COUNT_WIDTH'(INPUT_WIDTH - 1);
    localparam logic [WINDOW_WIDTH-1:0] WINDOW_END = WINDOW_WIDTH'(WINDOW - 1);

    state_e                  state_q, state_d;
    logic [INPUT_WIDTH-1:0]  word_q, word_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [WINDOW_WIDTH-1:0] window_q, window_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overflow_q, overflow_d;
`ifdef UNARY_POPCOUNT_EN
    logic [COUNT_WIDTH-1:0]  ones_q, ones_d;
`endif

    // Next-state: start always wins; DONE is entered on the last-bit or window-end edge
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        count_d     = count_q;
        window_d    = window_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
`ifdef UNARY_POPCOUNT_EN
        ones_d      = ones_q;
`endif
        if (start) begin
            state_d     = ST_CAPTURE;
            word_d      = '0;
            count_d     = '0;
            window_d    = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
`ifdef UNARY_POPCOUNT_EN
            ones_d      = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_CAPTURE: begin
                    if (window_q != WINDOW_END) begin
                        window_d = window_q + WINDOW_WIDTH'(1);
                    end
                    if (valid) begin
                        for (int i = 0; i < INPUT_WIDTH; i++) begin
                            if (COUNT_WIDTH'(i) == count_q) begin
                                word_d[i] = y;
                            end
                        end
                        count_d = count_q + COUNT_WIDTH'(1);
`ifdef UNARY_POPCOUNT_EN
                        if (y) begin
                            ones_d = ones_q + COUNT_WIDTH'(1);
                        end
`endif
                    end
                    if ((valid && (count_q == LAST_BIT)) || (window_q == WINDOW_END)) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (valid) begin
                        overflow_d = 1'b1;
                    end
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            count_q     <= '0;
            window_q    <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef UNARY_POPCOUNT_EN
            ones_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            count_q     <= count_d;
            window_q    <= window_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
`ifdef UNARY_POPCOUNT_EN
            ones_q      <= ones_d;
`endif
        end
    end

    assign word_out  = word_q;
    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
`ifdef UNARY_POPCOUNT_EN
    assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_unary_stream_collector.sv
// Directed-vector bench for unary_stream_collector; popcount checks are compiled in with UNARY_POPCOUNT_EN.
module tb_unary_stream_collector;

    localparam int unsigned INPUT_WIDTH = 8;
    localparam int unsigned COUNT_WIDTH = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   y;
    logic                   valid;
    logic [INPUT_WIDTH-1:0] word_out;
    logic [COUNT_WIDTH-1:0] count;
    logic                   out_valid;
    logic                   out_ready;
    logic                   overflow;
`ifdef UNARY_POPCOUNT_EN
    logic [COUNT_WIDTH-1:0] ones_count;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    unary_stream_collector #(.INPUT_WIDTH(INPUT_WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .y         (y),
        .valid     (valid),
        .word_out  (word_out),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
`ifdef UNARY_POPCOUNT_EN
        ,
        .ones_count(ones_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so inputs change and outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [INPUT_WIDTH-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            y     = w[i];
            tick();
        end
        valid = 1'b0;
        y     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int  lat;
    bit  seen;
    logic [INPUT_WIDTH-1:0] pat;

    initial begin
        reset = 1'b0; start = 1'b0; y = 1'b0; valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_word", 32'(word_out), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        reset = 1'b1;
        tick();

        // Full word: out_valid visible right after the edge that takes the 8th bit
        do_start();
        send_bits(8'hB1, 8);
        check("full_out_valid", 32'(out_valid), 32'h1);
        check("full_word", 32'(word_out), 32'hB1);
        check("full_count", 32'(count), 32'h8);
        check("full_overflow", 32'(overflow), 32'h0);
`ifdef UNARY_POPCOUNT_EN
        check("full_ones", 32'(ones_count), 32'h4);
`endif
        tick();
        check("full_hold_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_ack_valid", 32'(out_valid), 32'h0);
        check("full_retained", 32'(word_out), 32'hB1);

        // Gapped stream: 8 ones on alternate cycles finish before the window ends
        do_start();
        for (int i = 0; i < 16; i++) begin
            valid = (i % 2 == 0);
            y     = 1'b1;
            tick();
        end
        valid = 1'b0;
        check("gap_out_valid", 32'(out_valid), 32'h1);
        check("gap_word", 32'(word_out), 32'hFF);
        check("gap_count", 32'(count), 32'h8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Short stream: window of 17 capture edges, out_valid after the 17th edge past start
        pat = 8'h1B;
        do_start();
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            valid = (i < 5);
            y     = (i < 5) ? pat[i] : 1'b0;
            tick();
            lat++;
            if (out_valid) seen = 1'b1;
        end
        valid = 1'b0;
        check("short_latency", 32'(lat), 32'd17);
        check("short_word", 32'(word_out), 32'h1B);
        check("short_count", 32'(count), 32'h5);

        // Backpressure: hold in DONE, a stray valid sets sticky overflow and is dropped
        for (int i = 0; i < 10; i++) begin
            valid = (i == 3);
            y     = 1'b1;
            tick();
        end
        valid = 1'b0;
        check("bp_out_valid", 32'(out_valid), 32'h1);
        check("bp_word", 32'(word_out), 32'h1B);
        check("bp_count", 32'(count), 32'h5);
        check("bp_overflow", 32'(overflow), 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ack_valid", 32'(out_valid), 32'h0);
        check("bp_overflow_sticky", 32'(overflow), 32'h1);

        // Reset mid-capture, then a clean 0x5A capture
        do_start();
        check("start_clears_ovf", 32'(overflow), 32'h0);
        send_bits(8'h07, 3);
        check("mid_count", 32'(count), 32'h3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_word", 32'(word_out), 32'h0);
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        do_start();
        send_bits(8'h5A, 8);
        check("cap5a_word", 32'(word_out), 32'h5A);
        check("cap5a_count", 32'(count), 32'h8);
        check("cap5a_valid", 32'(out_valid), 32'h1);

        // Start with valid in the same cycle: that bit is not captured; start beats a pending handshake
        start = 1'b1; valid = 1'b1; y = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("restart_valid", 32'(out_valid), 32'h0);
        check("restart_count", 32'(count), 32'h0);
        send_bits(8'h00, 8);
        check("zero_word", 32'(word_out), 32'h00);
        check("zero_count", 32'(count), 32'h8);
`ifdef UNARY_POPCOUNT_EN
        check("zero_ones", 32'(ones_count), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
